// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush sequencer for the F-D-E-M-W pipeline: load-use,
//               dmem miss, multicycle MDU and taken-branch hazards.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_SELECT  = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_SELECT-1:0] i_reg_a_select_D,
  input  logic [REG_SELECT-1:0] i_reg_b_select_D,
  input  logic                  i_uses_b_D,
  input  logic                  i_is_load_E,
  input  logic [REG_SELECT-1:0] i_reg_c_select_E,
  input  logic                  i_branch_taken_E,
  input  logic                  i_mdu_busy_E,
  input  logic                  i_mdu_done,
  input  logic                  i_mem_req_M,
  input  logic                  i_mem_ready,
  output logic                  o_stall_F,
  output logic                  o_stall_D,
  output logic                  o_stall_E,
  output logic                  o_stall_M,
  output logic                  o_flush_D,
  output logic                  o_flush_E,
  output logic                  o_flush_M,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles,
  output logic                  o_mem_timeout
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_MDU_WAIT = 2'd2;

  localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] C_TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [TO_W-1:0]      r_to_cnt;
  logic [TO_W-1:0]      w_to_inc;
  logic                 r_mem_timeout;

  logic w_load_use, w_mem_miss, w_mdu_wait, w_release;
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_flush_m;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_load_use = i_is_load_E && (i_reg_c_select_E != '0) &&
                      ((i_reg_c_select_E == i_reg_a_select_D) ||
                       (i_uses_b_D && (i_reg_c_select_E == i_reg_b_select_D)));
  assign w_mem_miss = i_mem_req_M && !i_mem_ready;
  assign w_mdu_wait = i_mdu_busy_E && !i_mdu_done;

  always_comb begin
    w_next    = r_state;
    w_release = 1'b0;
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_miss) begin
          {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
          w_next = ST_MEM_WAIT;
        end else if (w_mdu_wait) begin
          {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
          w_flush_m = 1'b1;
          w_next    = ST_MDU_WAIT;
        end else begin
          w_release = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!i_mem_ready) begin
          {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
        end else begin
          w_release = 1'b1;
          w_next    = ST_RUN;
        end
      end
      ST_MDU_WAIT: begin
        if (!i_mdu_done) begin
          {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
          w_flush_m = 1'b1;
        end else begin
          w_release = 1'b1;
          w_next    = ST_RUN;
        end
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
    // A taken branch kills the instruction in D, so it outranks load-use
    if (w_release) begin
      if (i_branch_taken_E) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_load_use) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  // While reset is held the pipe is cleared by bubbles and nothing stalls
  assign o_stall_F = !i_rst && w_stall_f;
  assign o_stall_D = !i_rst && w_stall_d;
  assign o_stall_E = !i_rst && w_stall_e;
  assign o_stall_M = !i_rst && w_stall_m;
  assign o_flush_D = i_rst || w_flush_d;
  assign o_flush_E = i_rst || w_flush_e;
  assign o_flush_M = i_rst || w_flush_m;

  assign o_stall_cycles = r_stall_cycles;
  assign o_mem_timeout  = r_mem_timeout;

  assign w_to_inc = r_to_cnt + TO_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_RUN;
      r_stall_cycles <= '0;
      r_to_cnt       <= '0;
      r_mem_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_stall_f && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
      // Only cycles still waiting on dmem count toward the timeout
      if ((r_state == ST_RUN) && (w_next == ST_MEM_WAIT)) begin
        r_to_cnt <= '0;
      end else if ((MEM_TIMEOUT != 0) && (r_state == ST_MEM_WAIT) &&
                   !i_mem_ready && (r_to_cnt != C_TO_LIMIT)) begin
        r_to_cnt <= w_to_inc;
        if (w_to_inc == C_TO_LIMIT) begin
          r_mem_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       uses_b, is_load, br, mdu_busy, mdu_done, mem_req, mem_ready;

  logic        st_f, st_d, st_e, st_m, fl_d, fl_e, fl_m, mto;
  logic [15:0] scnt;
  logic        s_st_f, s_st_d, s_st_e, s_st_m, s_fl_d, s_fl_e, s_fl_m, s_mto;
  logic [1:0]  s_scnt;
  logic [6:0]  ctl;

  int n_tests = 0;
  int n_fail  = 0;

  assign ctl = {st_f, st_d, st_e, st_m, fl_d, fl_e, fl_m};

  hazard_ctrl #(.REG_SELECT(5), .CNT_WIDTH(16), .MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_reg_a_select_D(rs1), .i_reg_b_select_D(rs2), .i_uses_b_D(uses_b),
    .i_is_load_E(is_load), .i_reg_c_select_E(rd), .i_branch_taken_E(br),
    .i_mdu_busy_E(mdu_busy), .i_mdu_done(mdu_done),
    .i_mem_req_M(mem_req), .i_mem_ready(mem_ready),
    .o_stall_F(st_f), .o_stall_D(st_d), .o_stall_E(st_e), .o_stall_M(st_m),
    .o_flush_D(fl_d), .o_flush_E(fl_e), .o_flush_M(fl_m),
    .o_stall_cycles(scnt), .o_mem_timeout(mto)
  );

  // Narrow counter and disabled timeout exercise saturation and the disable path
  hazard_ctrl #(.REG_SELECT(5), .CNT_WIDTH(2), .MEM_TIMEOUT(0)) dut_sat (
    .i_clk(clk), .i_rst(rst),
    .i_reg_a_select_D(rs1), .i_reg_b_select_D(rs2), .i_uses_b_D(uses_b),
    .i_is_load_E(is_load), .i_reg_c_select_E(rd), .i_branch_taken_E(br),
    .i_mdu_busy_E(mdu_busy), .i_mdu_done(mdu_done),
    .i_mem_req_M(mem_req), .i_mem_ready(mem_ready),
    .o_stall_F(s_st_f), .o_stall_D(s_st_d), .o_stall_E(s_st_e), .o_stall_M(s_st_m),
    .o_flush_D(s_fl_d), .o_flush_E(s_fl_e), .o_flush_M(s_fl_m),
    .o_stall_cycles(s_scnt), .o_mem_timeout(s_mto)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; uses_b = 1'b0; is_load = 1'b0; br = 1'b0;
    mdu_busy = 1'b0; mdu_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // ctl bit order: stall F D E M, flush D E M
  initial begin
    idle();
    rst = 1'b1;
    #2;
    chk("reset_ctl", ctl, 7'b0000_111);
    chk("reset_cnt", scnt, 0);
    chk("reset_to", mto, 0);
    cyc(); cyc();
    rst = 1'b0;
    #1 chk("idle_ctl", ctl, 7'b0000_000);

    // lw x5 in E, add x6,x5,x1 in D
    cyc();
    is_load = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd1; uses_b = 1'b1;
    #1 chk("lu_rs1_ctl", ctl, 7'b1100_010);
    cyc(); idle();
    #1 chk("lu_after_ctl", ctl, 7'b0000_000);
    chk("lu_cnt", scnt, 1);

    // x0 destination and unused rs2 never hazard
    is_load = 1'b1; rd = 5'd0; rs1 = 5'd0;
    #1 chk("lu_x0_ctl", ctl, 7'b0000_000);
    rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5; uses_b = 1'b0;
    #1 chk("lu_nob_ctl", ctl, 7'b0000_000);
    uses_b = 1'b1;
    #1 chk("lu_rs2_ctl", ctl, 7'b1100_010);
    cyc();
    // taken branch overrides load-use
    rs1 = 5'd5; br = 1'b1;
    #1 chk("br_over_lu_ctl", ctl, 7'b0000_110);
    cyc(); idle();
    #1 chk("br_cnt", scnt, 2);

    // dmem miss for 3 cycles, ready with a taken branch on the 4th
    mem_req = 1'b1;
    #1 chk("miss0_ctl", ctl, 7'b1111_000);
    cyc();
    #1 chk("miss1_ctl", ctl, 7'b1111_000);
    cyc();
    #1 chk("miss2_ctl", ctl, 7'b1111_000);
    cyc();
    mem_ready = 1'b1; br = 1'b1;
    #1 chk("miss_rel_ctl", ctl, 7'b0000_110);
    cyc(); idle();
    #1 chk("miss_back_run", ctl, 7'b0000_000);
    chk("miss_cnt", scnt, 5);
    chk("miss_no_to", mto, 0);
    chk("sat_cnt", s_scnt, 3);

    // memory never ready: timeout after 4 MEM_WAIT cycles, FSM keeps waiting
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    #1 chk("to_before", mto, 0);
    chk("to_wait_ctl", ctl, 7'b1111_000);
    cyc();
    #1 chk("to_set", mto, 1);
    cyc();
    #1 chk("to_sticky", mto, 1);
    chk("to_still_wait", ctl, 7'b1111_000);
    chk("to_disabled", s_mto, 0);
    chk("sat_hold", s_scnt, 3);

    // asynchronous reset pulse between clock edges while in MEM_WAIT
    rst = 1'b1;
    #1 chk("arst_ctl", ctl, 7'b0000_111);
    chk("arst_cnt", scnt, 0);
    chk("arst_to", mto, 0);
    rst = 1'b0; idle();
    #1 chk("arst_state_run", ctl, 7'b0000_000);

    // MDU busy 5 cycles, then done together with a taken branch
    cyc();
    mdu_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("mdu_wait_ctl", ctl, 7'b1110_001);
      cyc();
    end
    mdu_done = 1'b1; br = 1'b1;
    #1 chk("mdu_rel_ctl", ctl, 7'b0000_110);
    cyc(); idle();
    #1 chk("mdu_after_ctl", ctl, 7'b0000_000);
    chk("mdu_cnt", scnt, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
